// File: rtl/dvp_pixel_packer_if.sv
// Pixel stream interface for the DVP packer output.
//   out_data  : packed RGB565 pixel
//   out_valid : pixel valid
//   out_sop   : first pixel of frame
//   out_eop   : last pixel of frame
//   out_ready : sink accepts when out_valid && out_ready
// master = pixel source, slave = pixel sink.
interface dvp_pixel_packer_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );
endinterface

// File: rtl/dvp_pixel_packer.sv
// DVP camera front end: registers the 8-bit DVP bus, packs byte pairs into
// 16-bit RGB565 pixels, crops to HSIZE x VSIZE and emits a pixel stream with
// start/end-of-frame markers. Runs entirely in the camera pixel-clock domain.
//
// Ports:
//   clk, reset_n         : pixel clock, asynchronous active-low reset
//   enable               : capture request (level)
//   dvp_data/href/vsync  : camera bus
//   pix                  : output pixel stream (master modport)
//   busy                 : FSM not idle
//   overflow, size_err   : sticky status, cleared at start of each frame
//   frame_done           : one-cycle pulse after the eop handshake
//   frame_count          : completed-frame counter (wraps)
module dvp_pixel_packer #(
    parameter int unsigned HSIZE     = 640,
    parameter int unsigned VSIZE     = 480,
    parameter bit          BYTE_SWAP = 1'b0,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [7:0]                 dvp_data,
    input  logic                       dvp_href,
    input  logic                       dvp_vsync,
    dvp_pixel_packer_if.master         pix,
    output logic                       busy,
    output logic                       overflow,
    output logic                       size_err,
    output logic                       frame_done,
    output logic [15:0]                frame_count
);

    localparam logic [11:0] HLIM  = 12'(HSIZE);
    localparam logic [11:0] VLIM  = 12'(VSIZE);
    localparam logic [11:0] HLAST = 12'(HSIZE - 1);
    localparam logic [11:0] VLAST = 12'(VSIZE - 1);

    typedef enum logic [2:0] {StIdle, StWaitVs, StActive, StDrop, StFrameEnd} state_e;

    state_e      state_q, state_d;
    logic [7:0]  data_q, byte0_q;
    logic        href_q, href_prev_q, vs_q, vs_prev_q, phase_q;
    logic [11:0] x_q, y_q;
    logic [15:0] out_data_q;
    logic        out_valid_q, out_sop_q, out_eop_q;
    logic        overflow_q, size_err_q, frame_done_q;
    logic [15:0] frame_count_q;

    logic        vs_rise, vs_fall, href_fall, pix_formed, in_window;
    logic        accept, can_load, pix_new, load, ovf_event;
    logic        eop_accept, frame_start, short_line, vs_early;
    logic [15:0] pix_word;
    state_e      after_frame;

    assign vs_rise    = vs_q & ~vs_prev_q;
    assign vs_fall    = ~vs_q & vs_prev_q;
    assign href_fall  = ~href_q & href_prev_q;
    assign pix_formed = href_q & phase_q;
    assign in_window  = (x_q < HLIM) && (y_q < VLIM);
    assign pix_word   = BYTE_SWAP ? {data_q, byte0_q} : {byte0_q, data_q};

    assign accept      = out_valid_q & pix.out_ready;
    assign can_load    = ~out_valid_q | pix.out_ready;
    assign pix_new     = (state_q == StActive) & pix_formed & in_window;
    assign load        = pix_new & can_load;
    assign ovf_event   = pix_new & ~can_load;
    // Overflow wins over a simultaneous eop handshake.
    assign eop_accept  = (state_q == StActive) & accept & out_eop_q & ~ovf_event;
    assign frame_start = (state_q == StWaitVs) & enable & vs_fall;
    assign short_line  = (state_q == StActive) & href_fall & (x_q < HLIM) & (y_q < VLIM);
    assign vs_early    = (state_q == StActive) & vs_rise & ~eop_accept;
    assign after_frame = enable ? StWaitVs : StIdle;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (enable) state_d = StWaitVs;
            StWaitVs: begin
                if (!enable)      state_d = StIdle;
                else if (vs_fall) state_d = StActive;
            end
            StActive: begin
                if (ovf_event)       state_d = StDrop;
                else if (eop_accept) state_d = vs_rise ? after_frame : StFrameEnd;
                else if (vs_rise)    state_d = after_frame;
            end
            StDrop, StFrameEnd: if (vs_rise) state_d = after_frame;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            data_q        <= '0;
            byte0_q       <= '0;
            href_q        <= 1'b0;
            href_prev_q   <= 1'b0;
            vs_q          <= 1'b0;
            vs_prev_q     <= 1'b0;
            phase_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            overflow_q    <= 1'b0;
            size_err_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= dvp_data;
            href_q      <= dvp_href;
            href_prev_q <= href_q;
            vs_q        <= VSYNC_POL ? dvp_vsync : ~dvp_vsync;
            vs_prev_q   <= vs_q;

            // Byte phase; an odd trailing byte is dropped when href falls.
            phase_q <= href_q ? ~phase_q : 1'b0;
            if (href_q && !phase_q) byte0_q <= data_q;

            // Counters saturate so an oversize input never wraps back into the window.
            if (frame_start || href_fall)            x_q <= '0;
            else if (pix_formed && (x_q != '1))      x_q <= x_q + 12'd1;

            if (frame_start)                         y_q <= '0;
            else if ((state_q == StActive) && href_fall && (y_q != '1))
                                                     y_q <= y_q + 12'd1;

            if (load) begin
                out_data_q  <= pix_word;
                out_valid_q <= 1'b1;
                out_sop_q   <= (x_q == '0) && (y_q == '0);
                out_eop_q   <= (x_q == HLAST) && (y_q == VLAST);
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end

            if (frame_start)     overflow_q <= 1'b0;
            else if (ovf_event)  overflow_q <= 1'b1;

            if (frame_start)                   size_err_q <= 1'b0;
            else if (short_line || vs_early)   size_err_q <= 1'b1;

            frame_done_q <= eop_accept;
            if (eop_accept) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign pix.out_data  = out_data_q;
    assign pix.out_valid = out_valid_q;
    assign pix.out_sop   = out_sop_q;
    assign pix.out_eop   = out_eop_q;
    assign busy          = (state_q != StIdle);
    assign overflow      = overflow_q;
    assign size_err      = size_err_q;
    assign frame_done    = frame_done_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_dvp_pixel_packer.sv
module tb_dvp_pixel_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  dvp_data;
    logic        dvp_href;
    logic        dvp_vsync;
    logic        busy, overflow, size_err, frame_done;
    logic [15:0] frame_count;
    logic        sw_busy, sw_overflow, sw_size_err, sw_frame_done;
    logic [15:0] sw_frame_count;

    dvp_pixel_packer_if pix_if ();
    dvp_pixel_packer_if sw_if ();

    dvp_pixel_packer #(
        .HSIZE(4), .VSIZE(2), .BYTE_SWAP(1'b0), .VSYNC_POL(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .dvp_data(dvp_data), .dvp_href(dvp_href), .dvp_vsync(dvp_vsync),
        .pix(pix_if), .busy(busy), .overflow(overflow), .size_err(size_err),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    dvp_pixel_packer #(
        .HSIZE(4), .VSIZE(2), .BYTE_SWAP(1'b1), .VSYNC_POL(1'b1)
    ) dut_sw (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .dvp_data(dvp_data), .dvp_href(dvp_href), .dvp_vsync(dvp_vsync),
        .pix(sw_if), .busy(sw_busy), .overflow(sw_overflow), .size_err(sw_size_err),
        .frame_done(sw_frame_done), .frame_count(sw_frame_count)
    );

    always #5 clk = ~clk;

    // Handshake recorder, sampled on the falling edge.
    logic [15:0] acc_data[$];
    bit          acc_sop[$];
    bit          acc_eop[$];
    logic [15:0] sw_data[$];
    int          fd_cnt = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (pix_if.out_valid && pix_if.out_ready) begin
                acc_data.push_back(pix_if.out_data);
                acc_sop.push_back(pix_if.out_sop);
                acc_eop.push_back(pix_if.out_eop);
            end
            if (sw_if.out_valid && sw_if.out_ready) sw_data.push_back(sw_if.out_data);
            if (frame_done) fd_cnt = fd_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;
    int bidx  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bgen(input int k);
        return 8'(32'h12 + 32'h22 * k);
    endfunction

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            dvp_href = 1'b1;
            dvp_data = bgen(bidx);
            bidx++;
            tick();
        end
    endtask

    task automatic end_line();
        dvp_href = 1'b0;
        dvp_data = 8'h00;
        repeat (4) tick();
    endtask

    task automatic vs_pulse();
        dvp_vsync = 1'b1;
        repeat (3) tick();
        dvp_vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic count_flags(input int from, output int nsop, output int neop);
        nsop = 0;
        neop = 0;
        for (int i = from; i < acc_sop.size(); i++) begin
            nsop += int'(acc_sop[i]);
            neop += int'(acc_eop[i]);
        end
    endtask

    logic [15:0] nom_exp [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDE00,
                                 16'h2244, 16'h6688, 16'hAACC, 16'hEE10};
    logic [15:0] ovs_exp [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDE00,
                                 16'hAACC, 16'hEE10, 16'h3254, 16'h7698};

    initial begin
        int base, fd0, ns, ne;
        reset_n = 1'b0;
        enable = 1'b0;
        dvp_data = 8'h00;
        dvp_href = 1'b0;
        dvp_vsync = 1'b0;
        pix_if.out_ready = 1'b1;
        sw_if.out_ready = 1'b1;
        repeat (3) tick();

        check("rst_valid", pix_if.out_valid, 0);
        check("rst_data", pix_if.out_data, 0);
        check("rst_sop_eop", {pix_if.out_sop, pix_if.out_eop}, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {overflow, size_err, frame_done}, 0);
        check("rst_count", frame_count, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Nominal 4x2 frame
        enable = 1'b1;
        repeat (2) tick();
        check("idle_to_wait_busy", busy, 1);
        vs_pulse();
        bidx = 0;
        base = acc_data.size();
        fd0 = fd_cnt;
        send_bytes(2);
        check("lat_edge1_valid", pix_if.out_valid, 0);
        send_bytes(1);
        check("lat_edge2_valid", pix_if.out_valid, 1);
        check("lat_edge2_data", pix_if.out_data, 16'h1234);
        check("lat_edge2_sop", pix_if.out_sop, 1);
        send_bytes(5);
        end_line();
        send_bytes(8);
        end_line();
        check("nom_npix", acc_data.size() - base, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("nom_pix%0d", i), acc_data[base + i], nom_exp[i]);
        count_flags(base, ns, ne);
        check("nom_nsop", ns, 1);
        check("nom_neop", ne, 1);
        check("nom_eop_last", acc_eop[base + 7], 1);
        check("nom_sop_first", acc_sop[base], 1);
        check("nom_frame_done", fd_cnt - fd0, 1);
        check("nom_frame_count", frame_count, 1);
        check("nom_size_err", size_err, 0);
        check("nom_overflow", overflow, 0);
        check("swap_pix0", sw_data[0], 16'h3412);
        check("swap_pix1", sw_data[1], 16'h7856);

        // Oversize: 6 pixels x 3 lines into 4x2
        vs_pulse();
        bidx = 0;
        base = acc_data.size();
        fd0 = fd_cnt;
        for (int l = 0; l < 3; l++) begin
            send_bytes(12);
            end_line();
        end
        check("ovs_npix", acc_data.size() - base, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("ovs_pix%0d", i), acc_data[base + i], ovs_exp[i]);
        check("ovs_eop_last", acc_eop[base + 7], 1);
        check("ovs_size_err", size_err, 0);
        check("ovs_frame_done", fd_cnt - fd0, 1);
        check("ovs_frame_count", frame_count, 2);

        // Short line, then vsync before eop
        vs_pulse();
        bidx = 0;
        base = acc_data.size();
        fd0 = fd_cnt;
        send_bytes(6);
        end_line();
        check("short_size_err", size_err, 1);
        dvp_vsync = 1'b1;
        repeat (4) tick();
        count_flags(base, ns, ne);
        check("short_npix", acc_data.size() - base, 3);
        check("short_neop", ne, 0);
        check("short_frame_done", fd_cnt - fd0, 0);
        check("short_frame_count", frame_count, 2);
        check("short_busy", busy, 1);
        check("short_err_held", size_err, 1);
        dvp_vsync = 1'b0;
        repeat (4) tick();
        check("rearm_size_err_clr", size_err, 0);

        // Backpressure: ready low for 4 clk mid-line
        bidx = 0;
        base = acc_data.size();
        fd0 = fd_cnt;
        send_bytes(3);
        pix_if.out_ready = 1'b0;
        send_bytes(4);
        check("bp_held_valid", pix_if.out_valid, 1);
        check("bp_held_data", pix_if.out_data, 16'h1234);
        check("bp_held_sop", pix_if.out_sop, 1);
        check("bp_overflow", overflow, 1);
        pix_if.out_ready = 1'b1;
        send_bytes(1);
        end_line();
        send_bytes(8);
        end_line();
        check("bp_npix", acc_data.size() - base, 1);
        check("bp_pix0", acc_data[base], 16'h1234);
        check("bp_frame_done", fd_cnt - fd0, 0);
        check("bp_overflow_sticky", overflow, 1);

        // Next frame recovers
        vs_pulse();
        check("rec_overflow_clr", overflow, 0);
        bidx = 0;
        base = acc_data.size();
        fd0 = fd_cnt;
        send_bytes(8);
        end_line();
        send_bytes(8);
        end_line();
        check("rec_npix", acc_data.size() - base, 8);
        check("rec_pix7", acc_data[base + 7], 16'hEE10);
        check("rec_frame_done", fd_cnt - fd0, 1);
        check("rec_frame_count", frame_count, 3);

        // Enable dropped mid-frame
        vs_pulse();
        bidx = 0;
        base = acc_data.size();
        fd0 = fd_cnt;
        send_bytes(8);
        end_line();
        enable = 1'b0;
        check("en_mid_busy", busy, 1);
        send_bytes(8);
        end_line();
        check("en_npix", acc_data.size() - base, 8);
        check("en_eop", acc_eop[base + 7], 1);
        check("en_frame_done", fd_cnt - fd0, 1);
        check("en_frame_count", frame_count, 4);
        check("en_frame_end_busy", busy, 1);
        dvp_vsync = 1'b1;
        repeat (4) tick();
        check("en_idle_busy", busy, 0);
        dvp_vsync = 1'b0;
        repeat (4) tick();
        check("en_stay_idle", busy, 0);

        // Reset mid-line
        enable = 1'b1;
        repeat (2) tick();
        vs_pulse();
        bidx = 0;
        send_bytes(3);
        check("prerst_valid", pix_if.out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("arst_valid", pix_if.out_valid, 0);
        check("arst_data", pix_if.out_data, 0);
        check("arst_count", frame_count, 0);
        check("arst_busy", busy, 0);
        dvp_href = 1'b0;
        #1;
        reset_n = 1'b1;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
